// File: rtl/pic_inta_sequencer.sv
// pic_inta_sequencer: 8259A-style interrupt sequencer. Picks the winning
// request against the in-service register, runs the two-pulse 8086 INTA
// handshake, drives the vector byte and owns the ISR including EOI handling.
module pic_inta_sequencer #(
  parameter logic [2:0] IDLE_VEC_SPURIOUS = 3'd7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] irr_pending,
  input  logic [7:0] imr,
  input  logic [4:0] vector_base,
  input  logic       aeoi,
  input  logic       inta_n,
  input  logic       eoi_valid,
  input  logic       eoi_specific,
  input  logic [2:0] eoi_level,
  output logic       int_out,
  output logic       inta_freeze,
  output logic [7:0] irr_clear,
  output logic [7:0] isr,
  output logic [7:0] data_out,
  output logic       data_oe
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    ACK1  = 3'd2,
    WAIT2 = 3'd3,
    ACK2  = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic       inta_n_q;
  logic       int_q, int_d;
  logic       freeze_q, freeze_d;
  logic [7:0] irr_clear_q, irr_clear_d;
  logic [7:0] isr_q, isr_d;
  logic [7:0] data_q, data_d;
  logic       oe_q, oe_d;
  logic [2:0] win_q, win_d;
  logic       spur_q, spur_d;

  logic       fall, rise;
  logic [7:0] allow;
  logic [7:0] eligible;
  logic [2:0] winner;
  logic [7:0] isr_set;
  logic [7:0] isr_clr;

  assign fall = inta_n_q & ~inta_n;
  assign rise = ~inta_n_q & inta_n;

  // A request may only preempt if it is strictly higher priority than every
  // level already in service, i.e. below the lowest set ISR bit.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_allow
      assign allow[gi] = ~|isr_q[gi:0];
    end
  endgenerate

  assign eligible = irr_pending & ~imr & allow;

  // Fixed priority encoder, IR0 highest.
  always_comb begin
    winner = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (eligible[i]) winner = i[2:0];
    end
  end

  // Next-state, handshake outputs and ISR update (set beats EOI clear).
  always_comb begin
    state_d     = state_q;
    int_d       = int_q;
    freeze_d    = freeze_q;
    irr_clear_d = 8'h00;
    data_d      = data_q;
    oe_d        = oe_q;
    win_d       = win_q;
    spur_d      = spur_q;
    isr_set     = 8'h00;
    isr_clr     = 8'h00;

    case (state_q)
      IDLE: begin
        if (|eligible) begin
          int_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (fall) begin
          if (|eligible) begin
            win_d       = winner;
            spur_d      = 1'b0;
            isr_set     = 8'h01 << winner;
            irr_clear_d = 8'h01 << winner;
          end else begin
            win_d  = IDLE_VEC_SPURIOUS;
            spur_d = 1'b1;
          end
          freeze_d = 1'b1;
          int_d    = 1'b0;
          state_d  = ACK1;
        end else if (~|eligible) begin
          int_d   = 1'b0;
          state_d = IDLE;
        end
      end
      ACK1: begin
        if (rise) state_d = WAIT2;
      end
      WAIT2: begin
        if (fall) begin
          data_d  = {vector_base, win_q};
          oe_d    = 1'b1;
          state_d = ACK2;
        end
      end
      ACK2: begin
        if (rise) begin
          oe_d     = 1'b0;
          freeze_d = 1'b0;
          if (aeoi && !spur_q) isr_clr = 8'h01 << win_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (eoi_valid) begin
      if (eoi_specific) isr_clr = isr_clr | (8'h01 << eoi_level);
      else              isr_clr = isr_clr | (isr_q & (~isr_q + 8'd1));
    end

    isr_d = (isr_q & ~isr_clr) | isr_set;
  end

  // State and output registers; reset abandons any handshake in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      inta_n_q    <= 1'b1;
      int_q       <= 1'b0;
      freeze_q    <= 1'b0;
      irr_clear_q <= 8'h00;
      isr_q       <= 8'h00;
      data_q      <= 8'h00;
      oe_q        <= 1'b0;
      win_q       <= 3'd0;
      spur_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      inta_n_q    <= inta_n;
      int_q       <= int_d;
      freeze_q    <= freeze_d;
      irr_clear_q <= irr_clear_d;
      isr_q       <= isr_d;
      data_q      <= data_d;
      oe_q        <= oe_d;
      win_q       <= win_d;
      spur_q      <= spur_d;
    end
  end

  assign int_out     = int_q;
  assign inta_freeze = freeze_q;
  assign irr_clear   = irr_clear_q;
  assign isr         = isr_q;
  assign data_out    = data_q;
  assign data_oe     = oe_q;

endmodule

// File: doc/pic_inta_sequencer.md
Name: pic_inta_sequencer

Overview:
- Control-logic sequencer for the 8259A-style PIC, sitting between the IRR block, the CPU INTA bus pins and the data-bus driver.
- Resolves the highest-priority unmasked pending request against the in-service register (ISR) and raises INT.
- Runs the two-pulse 8086-mode INTA handshake: freezes the IRR, clears the granted IRR bit, sets the ISR bit and drives the vector byte.
- Owns the ISR and executes automatic, non-specific and specific EOI.

Parameters:
- IDLE_VEC_SPURIOUS, 3'd7, IR level reported when nothing is eligible at the first INTA (spurious interrupt).

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- irr_pending  input  8  pending requests from IRR_priority; bit0 = IR0
- imr  input  8  interrupt mask, 1 = masked
- vector_base  input  5  ICW2 T7..T3
- aeoi  input  1  1 = auto-EOI at end of second INTA
- inta_n  input  1  CPU interrupt acknowledge, active low, already synchronised to clk
- eoi_valid  input  1  one-cycle EOI command strobe
- eoi_specific  input  1  1 = specific EOI, 0 = non-specific
- eoi_level  input  3  IR level for specific EOI
- int_out  output  1  interrupt request to CPU
- inta_freeze  output  1  to IRR INTA_FREEZE
- irr_clear  output  8  one-hot, one-cycle clear to IRR INTA_1
- isr  output  8  in-service register
- data_out  output  8  vector byte
- data_oe  output  1  data bus drive enable

Behaviour:
- Async reset while rst_n=0:
  - state=IDLE.
  - int_out, inta_freeze, data_oe = 0.
  - irr_clear, isr, data_out = 8'h00.
  - Takes effect mid-handshake, discarding any latched winner.
- Priority is fixed, IR0 highest.
  - eligible = irr_pending & ~imr, restricted to bits with index lower than the lowest set ISR bit (all bits if ISR = 0).
  - winner = lowest set index of eligible.
- INTA edges come from a registered inta_n_q (reset value 1):
  - fall = inta_n_q & ~inta_n
  - rise = ~inta_n_q & inta_n
- FSM states: IDLE, REQ, ACK1, WAIT2, ACK2.
- IDLE: if eligible != 0, go to REQ and set int_out=1 (registered, one cycle after eligibility appears).
- REQ:
  - If eligible becomes 0 before any fall: int_out=0, go to IDLE.
  - On fall (first INTA):
    - Latch win_q = winner, or IDLE_VEC_SPURIOUS if eligible = 0.
    - If not spurious, set isr[win_q] and pulse irr_clear[win_q] for exactly one cycle.
    - Set inta_freeze=1, int_out=0, go to ACK1.
    - data_oe stays 0.
- ACK1: on rise, go to WAIT2.
- WAIT2: on fall, set data_out={vector_base, win_q}, data_oe=1, go to ACK2. vector_base is sampled at this edge.
- ACK2: on rise:
  - Set data_oe=0 and inta_freeze=0.
  - If aeoi and not spurious, clear isr[win_q].
  - Go to IDLE.
  - data_out holds its last value.
- INTA pulses outside REQ/ACK1/WAIT2/ACK2 are ignored. A fall in IDLE does nothing.
- Changes to irr_pending or imr after the first fall do not alter win_q.
- EOI is accepted in any state when eoi_valid=1:
  - Non-specific: clear the lowest-index set ISR bit; no-op if ISR = 0.
  - Specific: clear isr[eoi_level].
  - If an EOI and an ISR set target the same bit in the same cycle, the set wins.
  - If they target different bits, both apply.
- Nesting: a new, higher-priority eligible request re-raises int_out from IDLE while lower ISR bits remain set.
- Spurious interrupt: ISR is untouched, irr_clear stays 0, and the vector is {vector_base, 3'd7}.

Test Plan:
- Reset mid-ACK1 (isr=8'h04, inta_freeze=1) → next cycle all outputs 0, state IDLE; a following fall is ignored.
- Basic: irr_pending=8'h28, imr=0, vector_base=5'b01000, aeoi=0 → int_out=1; first INTA → irr_clear=8'h08 for one cycle, isr=8'h08; second INTA → data_out=8'h43, data_oe=1 while inta_n low; after it, int_out=0 (IR5 is lower priority than the in-service IR3).
- Mask and spurious: irr_pending=8'h01 with int_out high, then imr=8'h01 before INTA, with one cycle of eligibility remaining at the fall → forced spurious: vector {base,3'd7}, isr unchanged, irr_clear=0.
- Nesting: isr=8'h10, irr_pending=8'h04 → handshake sets isr=8'h14; non-specific EOI → isr=8'h10; specific EOI level 4 → isr=8'h00.
- AEOI: aeoi=1, irr_pending=8'h80 → after the second rise, isr=8'h00 and inta_freeze drops in the same cycle.
- Simultaneous: a specific EOI for level 2 in the same cycle as the first-INTA set of IR2 → isr[2]=1.
